multi_debouncer: RTL

//   Parametrised N-channel push-button debouncer with per-channel synchroniser, stability counter and
//   one-cycle rise/fall event pulses. Sits between raw board inputs and control FSMs; replaces

---
 rtl/multi_debouncer.sv | 108 ++++++++++
 1 files changed

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer: synchroniser, stability counter and rise/fall pulses per channel.
// Optional long-press detection is compiled in when LONG_PRESS_EN is defined.
module multi_debouncer #(
    parameter int CHANNELS         = 4,
    parameter int CLK_FREQ         = 50_000_000,
    parameter int DEBOUNCE_TIME_MS = 1,
    parameter int SYNC_STAGES      = 2,
    parameter int HOLD_TIME_MS     = 1000
) (
    input  logic                clk,
    input  logic                rst_a_n,
    input  logic [CHANNELS-1:0] buttons_in,
    output logic [CHANNELS-1:0] buttons_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] long_press
);

    localparam int DEB_CYC = CLK_FREQ / 1000 * DEBOUNCE_TIME_MS;
    localparam int CNT_W   = (DEB_CYC < 1) ? 1 : $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    if (CHANNELS < 1 || DEB_CYC < 1 || SYNC_STAGES < 2 || HOLD_TIME_MS < 0) begin : g_bad_params
        $error("multi_debouncer: illegal parameter combination");
    end

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0]    r_cnt  [CHANNELS];
    logic [CHANNELS-1:0] r_out;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // A channel's level only moves after DEB_CYC consecutive synchronised samples disagree with it.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_cnt[ch] <= '0;
            end
            r_out  <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_sync[0] <= buttons_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_rise <= '0;
            r_fall <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (w_sync[ch] == r_out[ch]) begin
                    r_cnt[ch] <= '0;
                end else if (r_cnt[ch] == CNT_LAST) begin
                    r_cnt[ch]  <= '0;
                    r_out[ch]  <= w_sync[ch];
                    r_rise[ch] <= w_sync[ch];
                    r_fall[ch] <= ~w_sync[ch];
                end else begin
                    r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
                end
            end
        end
    end

    assign buttons_out = r_out;
    assign rise_pulse  = r_rise;
    assign fall_pulse  = r_fall;

`ifdef LONG_PRESS_EN
    localparam int HOLD_CYC = CLK_FREQ / 1000 * HOLD_TIME_MS;
    localparam int HOLD_W   = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    logic [HOLD_W-1:0]   r_hold [CHANNELS];
    logic [CHANNELS-1:0] r_long;

    // Saturating at HOLD_MAX gives exactly one pulse per press; release clears and re-arms.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_hold[ch] <= '0;
            end
            r_long <= '0;
        end else begin
            r_long <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (!r_out[ch]) begin
                    r_hold[ch] <= '0;
                end else if (r_hold[ch] != HOLD_MAX) begin
                    r_hold[ch] <= r_hold[ch] + HOLD_W'(1);
                    r_long[ch] <= (r_hold[ch] == HOLD_LAST);
                end
            end
        end
    end

    assign long_press = r_long;
`else
    assign long_press = '0;
`endif

endmodule
